// File: rtl/airlock_pkg.sv
// Shared types and constants for the airlock arbiter: FSM states, fault codes,
// completed-cycle counter width.
package airlock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_ACK,
    ST_RUN,
    ST_COOL,
    ST_FAULT
  } state_e;

  localparam logic [1:0] FAULT_NONE = 2'd0;
  localparam logic [1:0] FAULT_ILK  = 2'd1;
  localparam logic [1:0] FAULT_ACK  = 2'd2;
  localparam logic [1:0] FAULT_WDOG = 2'd3;

  localparam int CYCLES_W = 16;

  // Counter width able to hold values 0..maxval.
  function automatic int cnt_width(input int maxval);
    return (maxval < 2) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/airlock_rr_picker.sv
// Combinational one-hot round-robin pick among (req & mask), scanning upward from ptr.
// Zero latency; no handshake, the parent decides when the pick is consumed.
module airlock_rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt_oh,
  output logic [IW-1:0]   gnt_idx,
  output logic            gnt_vld
);

  logic found;
  int   pos;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = 0;
    for (int i = 0; i < NREQ; i++) begin
      pos = int'(ptr) + i;
      if (pos >= NREQ) pos = pos - NREQ;
      if (!found && req[pos] && mask[pos]) begin
        found       = 1'b1;
        gnt_idx     = IW'(pos);
        gnt_oh[pos] = 1'b1;
      end
    end
  end

  assign gnt_vld = found;

endmodule

// File: rtl/airlock_arbiter.sv
// Round-robin airlock grant sequencer with ack timeout, watchdog and cooldown; all outputs registered.
// Grant/start one edge after req is sampled in IDLE. Optional macro: ARB_PRIORITY_DEPART_EN.
module airlock_arbiter
  import airlock_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int COOLDOWN   = 16,
  parameter int ACK_CYCLES = 8,
  parameter int TIMEOUT    = 100000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     dir,
  input  logic                busy,
  input  logic                done,
  input  logic                ilk_error,
  output logic [NREQ-1:0]     grant,
  output logic                start,
  output logic                start_dir,
  output logic                fault,
  output logic [1:0]          fault_code,
  output logic [CYCLES_W-1:0] cycles
);

  localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int ACK_W = cnt_width(ACK_CYCLES);
  localparam int WD_W  = cnt_width(TIMEOUT);
  localparam int CL_W  = cnt_width(COOLDOWN);
  // The IDLE arbitration cycle is the final idle cycle, so COOL itself lasts COOLDOWN-1.
  localparam int COOL_LAST = (COOLDOWN > 1) ? COOLDOWN - 2 : 0;

  state_e              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic                start_q, start_d;
  logic                start_dir_q, start_dir_d;
  logic                fault_q, fault_d;
  logic [1:0]          fault_code_q, fault_code_d;
  logic [CYCLES_W-1:0] cycles_q, cycles_d;
  logic [ACK_W-1:0]    ack_cnt_q, ack_cnt_d;
  logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
  logic [CL_W-1:0]     cool_cnt_q, cool_cnt_d;

  logic [NREQ-1:0]     pick_mask;
  logic [NREQ-1:0]     pick_oh;
  logic [IW-1:0]       pick_idx;
  logic                pick_vld;

`ifdef ARB_PRIORITY_DEPART_EN
  assign pick_mask = (|(req & dir)) ? dir : '1;
`else
  assign pick_mask = '1;
`endif

  airlock_rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .req     (req),
    .mask    (pick_mask),
    .ptr     (ptr_q),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    start_d      = 1'b0;
    start_dir_d  = start_dir_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    cycles_d     = cycles_q;
    ack_cnt_d    = ack_cnt_q;
    wd_cnt_d     = wd_cnt_q;
    cool_cnt_d   = cool_cnt_q;

    // Interlock error outranks every other event in the same cycle.
    if (state_q != ST_FAULT && ilk_error) begin
      state_d      = ST_FAULT;
      grant_d      = '0;
      fault_d      = 1'b1;
      fault_code_d = FAULT_ILK;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            state_d     = ST_LAUNCH;
            grant_d     = pick_oh;
            start_d     = 1'b1;
            start_dir_d = dir[pick_idx];
            ptr_d       = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
          end
        end
        ST_LAUNCH: begin
          state_d   = ST_ACK;
          ack_cnt_d = '0;
        end
        ST_ACK: begin
          if (busy) begin
            state_d  = ST_RUN;
            wd_cnt_d = '0;
          end else if (ack_cnt_q == ACK_W'(ACK_CYCLES - 1)) begin
            state_d      = ST_FAULT;
            grant_d      = '0;
            fault_d      = 1'b1;
            fault_code_d = FAULT_ACK;
          end else begin
            ack_cnt_d = ack_cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (done || !busy) begin
            state_d    = ST_COOL;
            grant_d    = '0;
            cool_cnt_d = '0;
            if (cycles_q != '1) cycles_d = cycles_q + 1'b1;
          end else if (wd_cnt_q == WD_W'(TIMEOUT - 1)) begin
            state_d      = ST_FAULT;
            grant_d      = '0;
            fault_d      = 1'b1;
            fault_code_d = FAULT_WDOG;
          end else begin
            wd_cnt_d = wd_cnt_q + 1'b1;
          end
        end
        ST_COOL: begin
          if (cool_cnt_q >= CL_W'(COOL_LAST)) state_d = ST_IDLE;
          else                                cool_cnt_d = cool_cnt_q + 1'b1;
        end
        ST_FAULT: begin
          grant_d = '0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      grant_q      <= '0;
      start_q      <= 1'b0;
      start_dir_q  <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= FAULT_NONE;
      cycles_q     <= '0;
      ack_cnt_q    <= '0;
      wd_cnt_q     <= '0;
      cool_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      start_q      <= start_d;
      start_dir_q  <= start_dir_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      cycles_q     <= cycles_d;
      ack_cnt_q    <= ack_cnt_d;
      wd_cnt_q     <= wd_cnt_d;
      cool_cnt_q   <= cool_cnt_d;
    end
  end

  assign grant      = grant_q;
  assign start      = start_q;
  assign start_dir  = start_dir_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign cycles     = cycles_q;

endmodule

// File: tb/tb_airlock_arbiter.sv
// Directed bench for airlock_arbiter with a grant scoreboard (expected {dir, grant} per start).
module tb_airlock_arbiter;
  import airlock_pkg::*;

  localparam int NREQ       = 4;
  localparam int COOLDOWN   = 4;
  localparam int ACK_CYCLES = 8;
  localparam int TIMEOUT    = 20;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ-1:0]     dir = '0;
  logic                busy = 1'b0;
  logic                done = 1'b0;
  logic                ilk_error = 1'b0;
  logic [NREQ-1:0]     grant;
  logic                start;
  logic                start_dir;
  logic                fault;
  logic [1:0]          fault_code;
  logic [CYCLES_W-1:0] cycles;

  airlock_arbiter #(
    .NREQ       (NREQ),
    .COOLDOWN   (COOLDOWN),
    .ACK_CYCLES (ACK_CYCLES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .dir        (dir),
    .busy       (busy),
    .done       (done),
    .ilk_error  (ilk_error),
    .grant      (grant),
    .start      (start),
    .start_dir  (start_dir),
    .fault      (fault),
    .fault_code (fault_code),
    .cycles     (cycles)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int exp_cycles = 0;
  logic [NREQ:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Waits (bounded) for a start pulse and checks it against the scoreboard head.
  task automatic wait_start(input string tag, input int budget, output logic [NREQ-1:0] eg);
    logic [NREQ:0] e;
    int i;
    i = 0;
    while (!start && i < budget) begin
      tick(1);
      i++;
    end
    chk({tag, "_start"}, 32'(start), 32'd1);
    chk({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
    e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    eg = e[NREQ-1:0];
    chk({tag, "_grant"}, 32'(grant), 32'(e[NREQ-1:0]));
    chk({tag, "_start_dir"}, 32'(start_dir), 32'(e[NREQ]));
  endtask

  // Called in the LAUNCH cycle: busy for nbusy cycles, then a done pulse.
  task automatic serve(input string tag, input int nbusy, input logic [NREQ-1:0] eg);
    busy = 1'b1;
    tick(1);
    chk({tag, "_start_pulse"}, 32'(start), 32'd0);
    tick(nbusy - 1);
    chk({tag, "_grant_held"}, 32'(grant), 32'(eg));
    done = 1'b1;
    tick(1);
    done = 1'b0;
    busy = 1'b0;
    if (exp_cycles < 16'hFFFF) exp_cycles++;
    chk({tag, "_cycles"}, 32'(cycles), 32'(exp_cycles));
    chk({tag, "_grant_clr"}, 32'(grant), 32'd0);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic do_reset(input string tag);
    req = '0;
    busy = 1'b0;
    done = 1'b0;
    ilk_error = 1'b0;
    reset = 1'b0;
    #2;
    chk({tag, "_rst_grant"}, 32'(grant), 32'd0);
    chk({tag, "_rst_start"}, 32'(start), 32'd0);
    chk({tag, "_rst_sdir"}, 32'(start_dir), 32'd0);
    chk({tag, "_rst_fault"}, 32'(fault), 32'd0);
    chk({tag, "_rst_code"}, 32'(fault_code), 32'(FAULT_NONE));
    chk({tag, "_rst_cycles"}, 32'(cycles), 32'd0);
    exp_cycles = 0;
    sb_q.delete();
    tick(1);
    reset = 1'b1;
    tick(1);
  endtask

  initial begin
    logic [NREQ-1:0] eg;
    int ns;

    // Reset state
    tick(1);
    do_reset("init");

    // Round robin between bays 1 and 2
    req = 4'b0110;
    sb_q.push_back({1'b0, 4'b0010});
    sb_q.push_back({1'b0, 4'b0100});
    sb_q.push_back({1'b0, 4'b0010});
    sb_q.push_back({1'b0, 4'b0100});
    for (int k = 0; k < 4; k++) begin
      wait_start($sformatf("rr%0d", k), 40, eg);
      serve($sformatf("rr%0d", k), 5, eg);
      if (k == 3) req = 4'b0001;
      tick(1);
      chk($sformatf("rr%0d_cool_nogrant", k), 32'(grant), 32'd0);
    end

    // Interlock error coincident with done
    sb_q.push_back({1'b0, 4'b0001});
    wait_start("ilk", 40, eg);
    busy = 1'b1;
    tick(3);
    done = 1'b1;
    ilk_error = 1'b1;
    tick(1);
    done = 1'b0;
    ilk_error = 1'b0;
    busy = 1'b0;
    chk("ilk_fault", 32'(fault), 32'd1);
    chk("ilk_code", 32'(fault_code), 32'(FAULT_ILK));
    chk("ilk_cycles", 32'(cycles), 32'(exp_cycles));
    chk("ilk_grant", 32'(grant), 32'd0);
    ns = 0;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      ns += int'(start);
    end
    chk("ilk_no_restart", 32'(ns), 32'd0);
    chk("ilk_hold_fault", 32'(fault), 32'd1);
    chk("ilk_hold_code", 32'(fault_code), 32'(FAULT_ILK));

    // Ack timeout, with exact request latency after reset release
    do_reset("ack");
    req = 4'b0001;
    sb_q.push_back({1'b0, 4'b0001});
    tick(1);
    wait_start("ack", 0, eg);
    tick(8);
    chk("ack_nofault_8", 32'(fault), 32'd0);
    tick(1);
    chk("ack_fault_9", 32'(fault), 32'd1);
    chk("ack_code", 32'(fault_code), 32'(FAULT_ACK));
    chk("ack_grant", 32'(grant), 32'd0);

    // Watchdog
    do_reset("wd");
    req = 4'b0001;
    sb_q.push_back({1'b0, 4'b0001});
    tick(1);
    wait_start("wd", 0, eg);
    busy = 1'b1;
    tick(21);
    chk("wd_nofault_19", 32'(fault), 32'd0);
    tick(1);
    chk("wd_fault_20", 32'(fault), 32'd1);
    chk("wd_code", 32'(fault_code), 32'(FAULT_WDOG));
    chk("wd_grant", 32'(grant), 32'd0);
    busy = 1'b0;

    // Reset during RUN
    do_reset("pre");
    req = 4'b0001;
    sb_q.push_back({1'b0, 4'b0001});
    sb_q.push_back({1'b0, 4'b0001});
    tick(1);
    wait_start("run1", 0, eg);
    serve("run1", 3, eg);
    wait_start("run2", 40, eg);
    busy = 1'b1;
    tick(4);
    chk("run2_cycles", 32'(cycles), 32'd1);
    chk("run2_grant", 32'(grant), 32'd1);
    do_reset("midrun");
    req = 4'b0001;
    sb_q.push_back({1'b0, 4'b0001});
    tick(1);
    wait_start("post", 0, eg);
    chk("post_cycles", 32'(cycles), 32'd0);

    // Depart priority versus pure round robin
    do_reset("prio");
    req = 4'b1001;
    dir = 4'b1000;
`ifdef ARB_PRIORITY_DEPART_EN
    sb_q.push_back({1'b1, 4'b1000});
`else
    sb_q.push_back({1'b0, 4'b0001});
`endif
    sb_q.push_back({1'b1, 4'b1000});
    tick(1);
    wait_start("prio1", 0, eg);
    dir = 4'b0111;
    busy = 1'b1;
    tick(1);
    chk("prio1_dir_frozen", 32'(start_dir), 32'(sb_q.size() == 1 ? eg[3] : 1'bx));
    dir = 4'b1000;
    serve("prio1", 3, eg);
    wait_start("prio2", 40, eg);
    serve("prio2", 3, eg);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
